mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 255, maximum wait for mem_rdy in cycles (1..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  system clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  if_req  in  1  fetch request, held until if_gnt
  if_addr  in  ADDR_W  fetch address
  if_gnt  out  1  fetch accepted, 1-cycle pulse
  if_rvalid  out  1  fetch complete, 1-cycle pulse
  ls_req  in  1  load/store request, held until ls_gnt
  ls_we  in  1  1 = store, 0 = load
  ls_be  in  4  byte enables
  ls_addr  in  ADDR_W  load/store address
  ls_wdata  in  DATA_W  store data
  ls_gnt  out  1  load/store accepted, 1-cycle pulse
  ls_rvalid  out  1  load/store complete, 1-cycle pulse
  rdata  out  DATA_W  read data, shared, valid with either rvalid
  err  out  1  timeout flag, valid with either rvalid
  mem_req  out  1  memory access active
  mem_we  out  1  memory write strobe
  mem_be  out  4  memory byte enables
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdy  in  1  memory completes current access
  mem_rdata  in  DATA_W  memory read data, valid with mem_rdy

Function
REQ-004 The FSM SHALL have the states IDLE, BUSY_IF and BUSY_LS.
REQ-005 In IDLE on a clock edge with a request pending: the command SHALL be registered, the state SHALL move to BUSY_x, and x_gnt SHALL be 1 for exactly the first BUSY_x cycle.
REQ-006 Arbitration: a single request wins; on if_req and ls_req together, the master not granted last wins (round-robin).
REQ-007 The last-grant flag SHALL reset to IF, so LS wins the first tie.
REQ-008 For fetch transactions the captured command SHALL be mem_we=0 and mem_be=4'hF.
REQ-009 In BUSY_x, mem_req SHALL be 1 and mem_we/be/addr/wdata SHALL be driven only from the captured registers; they SHALL stay stable until completion.
REQ-010 When mem_rdy=1 is sampled in BUSY_x, the state SHALL return to IDLE, and in the next cycle x_rvalid=1 and err=0.
REQ-011 On a read completion, rdata SHALL be the registered mem_rdata.
REQ-012 On a write completion, rdata SHALL hold its previous value.
REQ-013 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle while mem_rdy=0.
REQ-014 When the counter reaches TIMEOUT, the block SHALL abort: go to IDLE, pulse x_rvalid with err=1 and rdata=0.
REQ-015 In the timeout cycle, mem_rdy=1 SHALL take precedence (normal completion).
REQ-016 mem_rdy SHALL be ignored in IDLE.
REQ-017 At least one IDLE cycle SHALL separate transactions; the minimum transaction is grant, 1 BUSY cycle, rvalid.
REQ-018 Requests arriving during BUSY SHALL wait and SHALL NOT be lost, because requesters hold them.
REQ-019 if_gnt and ls_gnt SHALL never both be 1.
REQ-020 if_rvalid and ls_rvalid SHALL never both be 1.

Reset
REQ-021 While rst_n=0, all outputs SHALL be 0, the state SHALL be IDLE, the counter SHALL be 0 and last-grant SHALL be IF, independent of clk.
REQ-022 A reset during BUSY SHALL drop the transaction with no rvalid; mem_req SHALL fall immediately.

Structure
REQ-023 State encodings, the IF/LS grant constants and the default widths SHALL live in a shared package, riscv_bus_pkg.
REQ-024 Tie-break logic plus the last-grant flag SHALL be a sub-module, rr_arb2.

Verification
REQ-025 Fetch read: if_req, addr 0x100; mem_rdy after 3 BUSY cycles with mem_rdata 0xDEADBEEF -> if_gnt 1 pulse, mem_addr 0x100, if_rvalid with rdata 0xDEADBEEF, err 0.
REQ-026 Simultaneous if_req and ls_req (store, be 4'b0011, wdata 0x1234) after reset -> LS granted first with mem_we=1 and be 0011, then IF granted after ls_rvalid.
REQ-027 Both requests held for 4 transactions -> grants alternate LS, IF, LS, IF.
REQ-028 mem_rdy never asserted, TIMEOUT=8 -> ls_rvalid with err=1 and rdata=0 exactly 8 BUSY cycles after grant.
REQ-029 rst_n driven low mid-BUSY (asynchronously) -> mem_req goes to 0 immediately, no rvalid, and the next request is serviced normally.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared types and defaults for the fetch / load-store memory arbiter.
// Holds FSM state encodings, master identifiers and default bus widths.
package riscv_bus_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyIf = 2'd1,
        StBusyLs = 2'd2
    } arb_state_e;

    typedef enum logic {
        MstIf = 1'b0,
        MstLs = 1'b1
    } mst_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin tie-break between fetch and load/store.
// The last-grant flag only moves when the caller accepts a grant (en).
module rr_arb2
    import riscv_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_if_i,
    input  logic req_ls_i,
    input  logic en_i,
    output logic gnt_if_o,
    output logic gnt_ls_o
);

    mst_e last_q, last_d;

    // On a tie the master that did not win last time gets the port.
    always_comb begin
        gnt_if_o = req_if_i & (~req_ls_i | (last_q == MstLs));
        gnt_ls_o = req_ls_i & (~req_if_i | (last_q == MstIf));
        last_d   = last_q;
        if (en_i && gnt_ls_o) begin
            last_d = MstLs;
        end else if (en_i && gnt_if_o) begin
            last_d = MstIf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= MstIf;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store masters with a wait timeout.
// Commands are captured on grant; the memory side is driven only from those registers.
module mem_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              ls_gnt_q, ls_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              arb_gnt_if, arb_gnt_ls, arb_en;
    logic              finish;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if_i (if_req),
        .req_ls_i (ls_req),
        .en_i     (arb_en),
        .gnt_if_o (arb_gnt_if),
        .gnt_ls_o (arb_gnt_ls)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        arb_en      = 1'b0;
        finish      = 1'b0;

        case (state_q)
            StIdle: begin
                // mem_rdy is deliberately not looked at here.
                if (arb_gnt_if) begin
                    state_d  = StBusyIf;
                    cnt_d    = '0;
                    we_d     = 1'b0;
                    be_d     = 4'hF;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    if_gnt_d = 1'b1;
                    arb_en   = 1'b1;
                end else if (arb_gnt_ls) begin
                    state_d  = StBusyLs;
                    cnt_d    = '0;
                    we_d     = ls_we;
                    be_d     = ls_be;
                    addr_d   = ls_addr;
                    wdata_d  = ls_wdata;
                    ls_gnt_d = 1'b1;
                    arb_en   = 1'b1;
                end
            end
            StBusyIf, StBusyLs: begin
                // A ready in the final wait cycle still wins over the timeout.
                if (mem_rdy) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (cnt_inc == TimeoutCnt) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            if_rvalid_d = (state_q == StBusyIf);
            ls_rvalid_d = (state_q == StBusyLs);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_req   = (state_q != StIdle);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign err       = err_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a request-level model predicts grant order,
// memory command, latency and response; a monitor compares whatever the DUT presents.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr;
    logic [3:0]    ls_be;
    logic [DW-1:0] ls_wdata;
    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, err;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we, mem_rdy;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // d = BUSY cycle (1-based) in which memory answers; d > TO means never in time.
    typedef struct {
        bit            we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   d;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        bit            is_ls;
        bit            we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   lat;
        bit            err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int unsigned   d;
        logic [DW-1:0] data;
    } mem_t;

    exp_t          exp_q[$];
    mem_t          mem_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            cycle = 0;
    int            done_cnt = 0;
    bit            last_ls = 1'b0;
    logic [DW-1:0] model_rdata = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic finish_bench();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic push(input req_t r, input bit is_ls);
        exp_t e;
        mem_t m;
        e.is_ls = is_ls;
        e.we    = is_ls ? r.we : 1'b0;
        e.be    = is_ls ? r.be : 4'hF;
        e.addr  = r.addr;
        e.wdata = r.wdata;
        e.lat   = (r.d < TO) ? r.d : TO;
        e.err   = (r.d > TO);
        if (e.err) model_rdata = '0;
        else if (!e.we) model_rdata = r.data;
        e.rdata = model_rdata;
        m.d     = r.d;
        m.data  = r.data;
        exp_q.push_back(e);
        mem_q.push_back(m);
    endtask

    // One round: the chosen masters raise requests together and hold them until granted.
    task automatic run_round(input bit want_if, input bit want_ls, input req_t ri, input req_t rl);
        bit order_ls[2];
        int n;
        int target;
        if (want_if && want_ls) begin
            order_ls[0] = !last_ls;
            order_ls[1] = last_ls;
            n = 2;
        end else begin
            order_ls[0] = want_ls;
            n = 1;
        end
        for (int i = 0; i < n; i++) push(order_ls[i] ? rl : ri, order_ls[i]);
        last_ls = order_ls[n-1];

        @(posedge clk); #1;
        target = done_cnt + n;
        if (want_if) begin
            if_req  = 1'b1;
            if_addr = ri.addr;
        end
        if (want_ls) begin
            ls_req   = 1'b1;
            ls_we    = rl.we;
            ls_be    = rl.be;
            ls_addr  = rl.addr;
            ls_wdata = rl.wdata;
        end
        for (int t = 0; t < 300 && done_cnt < target; t++) begin
            @(posedge clk); #1;
            if (if_gnt) begin
                if_req  = 1'b0;
                if_addr = $urandom;
            end
            if (ls_gnt) begin
                ls_req   = 1'b0;
                ls_we    = $urandom_range(0, 1);
                ls_be    = 4'($urandom);
                ls_addr  = $urandom;
                ls_wdata = $urandom;
            end
        end
        if (done_cnt < target) begin
            miscompares++;
            $display("FAIL round_timeout: got %0d completions, expected %0d", done_cnt, target);
            finish_bench();
        end
    endtask

    // Memory responder: answers in the scheduled BUSY cycle, noise on mem_rdy while idle.
    initial begin : responder
        int unsigned   k, d;
        logic [DW-1:0] dat;
        bit            act;
        mem_t          m;
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        act       = 1'b0;
        k         = 0;
        d         = 0;
        dat       = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                act     = 1'b0;
                mem_rdy = 1'b0;
            end else begin
                if ((if_gnt || ls_gnt) && mem_q.size() > 0) begin
                    m   = mem_q.pop_front();
                    d   = m.d;
                    dat = m.data;
                    k   = 0;
                    act = 1'b1;
                end
                if (mem_req && act) begin
                    k++;
                    mem_rdy   = (k == d);
                    mem_rdata = (k == d) ? dat : DW'($urandom);
                    if (k == d) act = 1'b0;
                end else if (!mem_req) begin
                    act       = 1'b0;
                    mem_rdy   = ($urandom_range(0, 2) == 0);
                    mem_rdata = $urandom;
                end else begin
                    mem_rdy = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        bit   busy;
        int   gcyc;
        exp_t cur;
        busy = 1'b0;
        gcyc = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (if_gnt || ls_gnt) begin
                    chk("gnt_onehot", 64'(if_gnt & ls_gnt), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_gnt", 64'(ls_gnt), 64'(2));
                    end else begin
                        cur  = exp_q[0];
                        busy = 1'b1;
                        gcyc = cycle;
                        chk("gnt_master_is_ls", 64'(ls_gnt), 64'(cur.is_ls));
                    end
                end
                if (busy && mem_req) begin
                    chk("mem_we_be", {mem_we, mem_be}, {cur.we, cur.be});
                    chk("mem_addr", mem_addr, cur.addr);
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
                if (if_rvalid || ls_rvalid) begin
                    chk("rvalid_onehot", 64'(if_rvalid & ls_rvalid), 64'd0);
                    if (!busy || exp_q.size() == 0) begin
                        chk("unexpected_rvalid", 64'(ls_rvalid), 64'(2));
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rvalid_master_is_ls", 64'(ls_rvalid), 64'(cur.is_ls));
                        chk("err", 64'(err), 64'(cur.err));
                        chk("rdata", rdata, cur.rdata);
                        chk("latency", 64'(cycle - gcyc), 64'(cur.lat));
                        chk("mem_req_after_done", 64'(mem_req), 64'd0);
                        busy = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        miscompares++;
        $display("FAIL watchdog: got no end of test, expected end before 500000");
        finish_bench();
    end

    function automatic req_t rand_req();
        req_t r;
        r.we    = $urandom_range(0, 1);
        r.be    = 4'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.d     = $urandom_range(1, TO + 2);
        r.data  = $urandom;
        return r;
    endfunction

    initial begin : main
        req_t ri, rl;
        int   kind;
        bit   saw;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_be    = '0;
        ls_addr  = '0;
        ls_wdata = '0;

        #12;
        chk("reset_ctrl", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, err, mem_req, mem_we, mem_be},
            64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_wdata", mem_wdata, 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight after reset: LS store first, then the fetch.
        ri = '{we: 1'b0, be: 4'hF, addr: 32'h200, wdata: '0, d: 2, data: 32'hCAFE0001};
        rl = '{we: 1'b1, be: 4'b0011, addr: 32'h80, wdata: 32'h1234, d: 1, data: 32'h55AA55AA};
        run_round(1'b1, 1'b1, ri, rl);

        ri = '{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: '0, d: 3, data: 32'hDEADBEEF};
        run_round(1'b1, 1'b0, ri, rl);

        // Two back-to-back ties: LS, IF, LS, IF.
        for (int i = 0; i < 2; i++) begin
            ri = rand_req();
            rl = rand_req();
            ri.d = 2;
            rl.d = 1;
            run_round(1'b1, 1'b1, ri, rl);
        end

        // Timeout, then ready exactly in the last allowed cycle.
        rl = '{we: 1'b0, be: 4'hF, addr: 32'h300, wdata: '0, d: 1000, data: 32'h11111111};
        run_round(1'b0, 1'b1, ri, rl);
        rl = '{we: 1'b0, be: 4'hC, addr: 32'h304, wdata: '0, d: TO, data: 32'h22222222};
        run_round(1'b0, 1'b1, ri, rl);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            ri   = rand_req();
            rl   = rand_req();
            run_round(kind != 1, kind != 0, ri, rl);
        end

        // Asynchronous reset in the middle of a load that never completes.
        rl = '{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: '0, d: 1000, data: 32'h0};
        push(rl, 1'b1);
        @(posedge clk); #1;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_be   = 4'hF;
        ls_addr = 32'h400;
        saw     = 1'b0;
        for (int t = 0; t < 20 && !saw; t++) begin
            @(posedge clk); #1;
            saw = ls_gnt;
        end
        chk("reset_test_gnt", 64'(saw), 64'd1);
        ls_req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mem_req", 64'(mem_req), 64'd0);
        chk("async_reset_ctrl", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, err, mem_we, mem_be},
            64'd0);
        exp_q.delete();
        mem_q.delete();
        last_ls     = 1'b0;
        model_rdata = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rvalid_in_reset", {if_rvalid, ls_rvalid, mem_req}, 64'd0);
        end
        #2;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("no_rvalid_after_reset", {if_rvalid, ls_rvalid, mem_req}, 64'd0);
        end

        ri = '{we: 1'b0, be: 4'hF, addr: 32'h500, wdata: '0, d: 2, data: 32'hA5A5A5A5};
        rl = '{we: 1'b0, be: 4'h3, addr: 32'h504, wdata: '0, d: 4, data: 32'h0BADF00D};
        run_round(1'b1, 1'b1, ri, rl);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        finish_bench();
    end

endmodule
